// File: rtl/aer_sample_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aer_sample_sequencer_pkg
// Description : Shared constants for the AER sample sequencer: default bus
//               widths, the timestep-tick address and the state encodings of
//               the sequencer and of the 4-phase transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package aer_sample_sequencer_pkg;

  localparam int c_AER_WIDTH           = 12;
  localparam int c_PRE_NEUR_ADDR_WIDTH = 10;
  localparam int c_PRE_NEUR_DATA_WIDTH = 8;

  // End-of-timestep tick is the all-ones AER address.
  localparam logic [c_AER_WIDTH-1:0] c_TICK_ADDR = '1;

  // Sequencer states. The transmitter owns the REQ/REL phases, so the
  // sequencer only needs one "waiting on transmitter" state per traffic type.
  localparam logic [2:0] c_S_IDLE      = 3'd0;
  localparam logic [2:0] c_S_RD        = 3'd1;
  localparam logic [2:0] c_S_CMP       = 3'd2;
  localparam logic [2:0] c_S_EV        = 3'd3;
  localparam logic [2:0] c_S_TK        = 3'd4;
  localparam logic [2:0] c_S_WAIT_DONE = 3'd5;
  localparam logic [2:0] c_S_DONE      = 3'd6;

  // 4-phase transmitter states.
  localparam logic [1:0] c_TX_IDLE = 2'd0;
  localparam logic [1:0] c_TX_REQ  = 2'd1;
  localparam logic [1:0] c_TX_REL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/aer_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : aer_sample_sequencer_if
// Description : Link between the sequencer and the SNN core: AER input bus,
//               held sample attributes and sample-finish/goodness return.
// Ports       : AERIN_ADDR/AERIN_REQ/AERIN_ACK - 4-phase AER event bus
//               IS_POS/IS_TRAIN                - held sample attributes
//               CORE_DONE/CORE_GOODNESS        - core sample-finish result
//               modport master = sequencer side, slave = core side
// Revision    : 1.0 - initial release
// ============================================================================
interface aer_sample_sequencer_if
  import aer_sample_sequencer_pkg::*;
#(
  parameter int AER_WIDTH = c_AER_WIDTH
);
  logic [AER_WIDTH-1:0] AERIN_ADDR;
  logic                 AERIN_REQ;
  logic                 AERIN_ACK;
  logic                 IS_POS;
  logic                 IS_TRAIN;
  logic                 CORE_DONE;
  logic [31:0]          CORE_GOODNESS;

  modport master (
    output AERIN_ADDR, AERIN_REQ, IS_POS, IS_TRAIN,
    input  AERIN_ACK, CORE_DONE, CORE_GOODNESS
  );

  modport slave (
    input  AERIN_ADDR, AERIN_REQ, IS_POS, IS_TRAIN,
    output AERIN_ACK, CORE_DONE, CORE_GOODNESS
  );
endinterface
`default_nettype wire

// File: rtl/aer_sample_sequencer_aer_4phase_tx.sv
`default_nettype none
// ============================================================================
// Module      : aer_4phase_tx
// Description : 4-phase AER transmitter. A send pulse captures the address
//               and raises REQ; ACK high drops REQ; ACK low completes with a
//               one-cycle done pulse. A new send may be accepted in the
//               completing cycle so back-to-back transfers lose no cycle.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_send, i_addr   - start a transfer with this address
//               i_abort          - return to idle immediately, REQ low
//               i_ack            - AER acknowledge
//               o_req, o_addr    - AER request and address
//               o_done           - transfer complete (ACK released)
//               o_stage          - current transmitter state
// Revision    : 1.0 - initial release
// ============================================================================
module aer_4phase_tx
  import aer_sample_sequencer_pkg::*;
#(
  parameter int AW = c_AER_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_send,
  input  logic          i_abort,
  input  logic [AW-1:0] i_addr,
  input  logic          i_ack,
  output logic          o_req,
  output logic [AW-1:0] o_addr,
  output logic          o_done,
  output logic [1:0]    o_stage
);

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_TX_IDLE;
      r_addr  <= '0;
    end else if (i_abort) begin
      r_state <= c_TX_IDLE;
    end else begin
      case (r_state)
        c_TX_IDLE: begin
          if (i_send) begin
            r_addr  <= i_addr;
            r_state <= c_TX_REQ;
          end
        end
        // An ACK already high on entry still leaves REQ up for this cycle.
        c_TX_REQ: begin
          if (i_ack) r_state <= c_TX_REL;
        end
        c_TX_REL: begin
          if (!i_ack) begin
            if (i_send) begin
              r_addr  <= i_addr;
              r_state <= c_TX_REQ;
            end else begin
              r_state <= c_TX_IDLE;
            end
          end
        end
        default: r_state <= c_TX_IDLE;
      endcase
    end
  end

  assign o_req   = (r_state == c_TX_REQ);
  assign o_addr  = r_addr;
  assign o_done  = (r_state == c_TX_REL) && !i_ack;
  assign o_stage = r_state;

endmodule
`default_nettype wire

// File: rtl/aer_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aer_sample_sequencer
// Description : Streams one rate-coded sample into the SNN core. For each
//               timestep t it scans every input neuron, emitting an AER event
//               when its spike count exceeds t, then emits a tick (all-ones
//               address). After the last timestep it waits for the core's
//               sample-finish and captures the goodness value.
// Option      : AER_WATCHDOG_EN - handshake/finish watchdog driving AER_ERR;
//               without it AER_ERR is 0 and all waits are unbounded.
// Ports       : CLK, RST            - clock, synchronous active-high reset
//               START/POS_IN/TRAIN_IN - host sample request and attributes
//               BUSY, SAMPLE_DONE   - sample in progress / completion pulse
//               GOODNESS_OUT        - captured core goodness
//               CNT_RD_*            - spike-count RAM read port (1-cycle)
//               AER_ERR             - sticky watchdog error
//               aer                 - core link (AER bus, attributes, finish)
// Revision    : 1.0 - initial release
// ============================================================================
module aer_sample_sequencer
  import aer_sample_sequencer_pkg::*;
#(
  parameter int TIME_STEP           = 8,
  parameter int INPUT_NEURON        = 784,
  parameter int AER_WIDTH           = c_AER_WIDTH,
  parameter int PRE_NEUR_ADDR_WIDTH = c_PRE_NEUR_ADDR_WIDTH,
  parameter int PRE_NEUR_DATA_WIDTH = c_PRE_NEUR_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic                           POS_IN,
  input  logic                           TRAIN_IN,
  output logic                           BUSY,
  output logic                           SAMPLE_DONE,
  output logic [31:0]                    GOODNESS_OUT,
  output logic                           CNT_RD_EN,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0] CNT_RD_ADDR,
  input  logic [PRE_NEUR_DATA_WIDTH-1:0] CNT_RD_DATA,
  output logic                           AER_ERR,
  aer_sample_sequencer_if.master         aer
);

  localparam int c_T_W = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;

  logic [2:0]                     r_state;
  logic [c_T_W-1:0]               r_t;
  logic [PRE_NEUR_ADDR_WIDTH-1:0] r_idx;
  logic                           r_is_pos;
  logic                           r_is_train;
  logic [31:0]                    r_goodness;
  logic                           r_done_seen;
  logic [31:0]                    r_early_good;

  logic                 w_fire;
  logic                 w_last_idx;
  logic                 w_last_t;
  logic                 w_send;
  logic [AER_WIDTH-1:0] w_tx_addr;
  logic                 w_tx_req;
  logic [AER_WIDTH-1:0] w_tx_aer_addr;
  logic                 w_tx_done;
  logic [1:0]           w_tx_stage;
  logic                 w_timeout;

  assign w_fire     = 32'(CNT_RD_DATA) > 32'(r_t);
  assign w_last_idx = (32'(r_idx) == INPUT_NEURON - 1);
  assign w_last_t   = (32'(r_t) == TIME_STEP - 1);

  // A tick is launched either straight from CMP (last neuron silent) or
  // chained onto the completing event of the last neuron.
  assign w_send = ((r_state == c_S_CMP) && (w_fire || w_last_idx)) ||
                  ((r_state == c_S_EV) && w_tx_done && w_last_idx);
  assign w_tx_addr = ((r_state == c_S_CMP) && w_fire) ? AER_WIDTH'(r_idx)
                                                      : {AER_WIDTH{1'b1}};

  aer_4phase_tx #(
    .AW(AER_WIDTH)
  ) u_tx (
    .clk     (CLK),
    .rst     (RST),
    .i_send  (w_send),
    .i_abort (w_timeout),
    .i_addr  (w_tx_addr),
    .i_ack   (aer.AERIN_ACK),
    .o_req   (w_tx_req),
    .o_addr  (w_tx_aer_addr),
    .o_done  (w_tx_done),
    .o_stage (w_tx_stage)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= c_S_IDLE;
      r_t          <= '0;
      r_idx        <= '0;
      r_is_pos     <= 1'b0;
      r_is_train   <= 1'b0;
      r_goodness   <= '0;
      r_done_seen  <= 1'b0;
      r_early_good <= '0;
    end else begin
      // Core may finish before the scan does; remember it and its result.
      if (aer.CORE_DONE && (r_state != c_S_IDLE) &&
          (r_state != c_S_WAIT_DONE) && (r_state != c_S_DONE)) begin
        r_done_seen  <= 1'b1;
        r_early_good <= aer.CORE_GOODNESS;
      end

      case (r_state)
        c_S_IDLE: begin
          if (START) begin
            r_is_pos    <= POS_IN;
            r_is_train  <= TRAIN_IN;
            r_t         <= '0;
            r_idx       <= '0;
            r_done_seen <= 1'b0;
            r_state     <= c_S_RD;
          end
        end
        c_S_RD: r_state <= c_S_CMP;
        c_S_CMP: begin
          if (w_fire)           r_state <= c_S_EV;
          else if (w_last_idx)  r_state <= c_S_TK;
          else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= c_S_RD;
          end
        end
        c_S_EV: begin
          if (w_tx_done) begin
            if (w_last_idx) r_state <= c_S_TK;
            else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= c_S_RD;
            end
          end
        end
        c_S_TK: begin
          if (w_tx_done) begin
            if (w_last_t) r_state <= c_S_WAIT_DONE;
            else begin
              r_t     <= r_t + 1'b1;
              r_idx   <= '0;
              r_state <= c_S_RD;
            end
          end
        end
        c_S_WAIT_DONE: begin
          if (aer.CORE_DONE) begin
            r_goodness <= aer.CORE_GOODNESS;
            r_state    <= c_S_DONE;
          end else if (r_done_seen) begin
            r_goodness <= r_early_good;
            r_state    <= c_S_DONE;
          end
        end
        c_S_DONE: r_state <= c_S_IDLE;
        default:  r_state <= c_S_IDLE;
      endcase

      if (w_timeout) r_state <= c_S_IDLE;
    end
  end

`ifdef AER_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
  logic [2:0]  r_state_q;
  logic [1:0]  r_tx_q;
  logic        r_aer_err;
  logic        w_wd_active;
  logic        w_same;
  logic [15:0] w_wd_eff;

  // Count cycles spent in the current (sequencer, transmitter) state pair;
  // any change of either restarts the count.
  assign w_wd_active = (r_state == c_S_EV) || (r_state == c_S_TK) ||
                       (r_state == c_S_WAIT_DONE);
  assign w_same      = (r_state == r_state_q) && (w_tx_stage == r_tx_q);
  assign w_wd_eff    = w_same ? r_wd_cnt : 16'd0;
  assign w_timeout   = w_wd_active && (32'(w_wd_eff) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wd_cnt  <= '0;
      r_state_q <= c_S_IDLE;
      r_tx_q    <= c_TX_IDLE;
      r_aer_err <= 1'b0;
    end else begin
      r_state_q <= r_state;
      r_tx_q    <= w_tx_stage;
      r_wd_cnt  <= w_wd_active ? (w_wd_eff + 16'd1) : 16'd0;
      if (w_timeout)                        r_aer_err <= 1'b1;
      else if ((r_state == c_S_IDLE) && START) r_aer_err <= 1'b0;
    end
  end

  assign AER_ERR = r_aer_err;
`else
  logic w_unused_wd;
  assign w_unused_wd = (TIMEOUT_CYCLES != 0) ^ (^w_tx_stage);
  assign w_timeout   = 1'b0;
  assign AER_ERR     = 1'b0;
`endif

  assign BUSY           = (r_state != c_S_IDLE);
  assign SAMPLE_DONE    = (r_state == c_S_DONE);
  assign GOODNESS_OUT   = r_goodness;
  assign CNT_RD_EN      = (r_state == c_S_RD);
  assign CNT_RD_ADDR    = r_idx;
  assign aer.AERIN_REQ  = w_tx_req;
  assign aer.AERIN_ADDR = w_tx_aer_addr;
  assign aer.IS_POS     = r_is_pos;
  assign aer.IS_TRAIN   = r_is_train;

endmodule
`default_nettype wire

// File: tb/tb_aer_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aer_sample_sequencer
// Description : Self-checking bench for aer_sample_sequencer with 4 input
//               neurons and 2 timesteps. Expected AER address streams are
//               built from the count table into a queue and compared against
//               the addresses the core-side monitor records.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aer_sample_sequencer;

  localparam int c_N  = 4;
  localparam int c_T  = 2;
  localparam int c_TO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        POS_IN = 1'b0;
  logic        TRAIN_IN = 1'b0;
  logic        BUSY, SAMPLE_DONE, CNT_RD_EN, AER_ERR;
  logic [31:0] GOODNESS_OUT;
  logic [9:0]  CNT_RD_ADDR;
  logic [7:0]  CNT_RD_DATA = '0;

  aer_sample_sequencer_if bus ();

  aer_sample_sequencer #(
    .TIME_STEP      (c_T),
    .INPUT_NEURON   (c_N),
    .TIMEOUT_CYCLES (c_TO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .POS_IN       (POS_IN),
    .TRAIN_IN     (TRAIN_IN),
    .BUSY         (BUSY),
    .SAMPLE_DONE  (SAMPLE_DONE),
    .GOODNESS_OUT (GOODNESS_OUT),
    .CNT_RD_EN    (CNT_RD_EN),
    .CNT_RD_ADDR  (CNT_RD_ADDR),
    .CNT_RD_DATA  (CNT_RD_DATA),
    .AER_ERR      (AER_ERR),
    .aer          (bus.master)
  );

  always #5 CLK = ~CLK;

  // Count RAM: registered read, data one cycle after the enable.
  logic [7:0] mem [c_N];
  always @(posedge CLK) if (CNT_RD_EN) CNT_RD_DATA <= mem[CNT_RD_ADDR[1:0]];

  // Core-side ACK: 0 = combinational echo of REQ, 1 = REQ delayed 1 cycle,
  // 2 = never acknowledge.
  int   ack_mode = 0;
  logic ack_dly  = 1'b0;
  always @(posedge CLK) ack_dly <= bus.AERIN_REQ;
  assign bus.AERIN_ACK = (ack_mode == 0) ? bus.AERIN_REQ :
                         (ack_mode == 1) ? ack_dly : 1'b0;

  // Monitor: record each new request's address and count completion pulses.
  logic [11:0] obs_q [$];
  logic [11:0] exp_q [$];
  logic        prev_req = 1'b0;
  int          n_done   = 0;
  always @(negedge CLK) begin
    if (RST) prev_req = 1'b0;
    else begin
      if (bus.AERIN_REQ && !prev_req) obs_q.push_back(bus.AERIN_ADDR);
      prev_req = bus.AERIN_REQ;
      if (SAMPLE_DONE) n_done++;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Reference stream: neuron i fires at timestep t while count > t, then a tick.
  task automatic build_exp();
    exp_q.delete();
    for (int t = 0; t < c_T; t++) begin
      for (int i = 0; i < c_N; i++)
        if (int'(mem[i]) > t) exp_q.push_back(12'(i));
      exp_q.push_back(12'hFFF);
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_addr"}, obs_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic start_sample(input logic pos, input logic train);
    POS_IN   = pos;
    TRAIN_IN = train;
    START    = 1'b1;
    step();
    START    = 1'b0;
  endtask

  initial begin
    int k;
    int n_exp;
    bus.CORE_DONE     = 1'b0;
    bus.CORE_GOODNESS = '0;
    repeat (3) step();

    // ---- reset state ----
    chk("rst_busy", BUSY, 0);
    chk("rst_sample_done", SAMPLE_DONE, 0);
    chk("rst_goodness", GOODNESS_OUT, 0);
    chk("rst_rd_en", CNT_RD_EN, 0);
    chk("rst_rd_addr", CNT_RD_ADDR, 0);
    chk("rst_req", bus.AERIN_REQ, 0);
    chk("rst_addr", bus.AERIN_ADDR, 0);
    chk("rst_is_pos", bus.IS_POS, 0);
    chk("rst_is_train", bus.IS_TRAIN, 0);
    chk("rst_aer_err", AER_ERR, 0);
    RST = 1'b0;
    step();

    // ---- sample 1: counts {0,1,2,5}, ACK one cycle behind REQ ----
    mem[0] = 8'd0; mem[1] = 8'd1; mem[2] = 8'd2; mem[3] = 8'd5;
    ack_mode = 1;
    build_exp();
    n_exp = exp_q.size();
    obs_q.delete();
    start_sample(1'b1, 1'b0);
    chk("s1_busy", BUSY, 1);
    chk("s1_is_pos", bus.IS_POS, 1);
    chk("s1_is_train", bus.IS_TRAIN, 0);
    k = 0;
    while (!(obs_q.size() == n_exp && !bus.AERIN_REQ) && k < 300) begin
      step();
      k++;
    end
    chk("s1_scan_in_time", k < 300, 1);
    repeat (4) step();
    chk("s1_waiting_busy", BUSY, 1);
    chk("s1_no_done_yet", n_done, 0);
    bus.CORE_DONE     = 1'b1;
    bus.CORE_GOODNESS = 32'h0000_1234;
    step();
    bus.CORE_DONE     = 1'b0;
    bus.CORE_GOODNESS = '0;
    chk("s1_sample_done", SAMPLE_DONE, 1);
    chk("s1_goodness", GOODNESS_OUT, 32'h0000_1234);
    step();
    chk("s1_done_pulse_len", SAMPLE_DONE, 0);
    chk("s1_idle_busy", BUSY, 0);
    chk("s1_done_count", n_done, 1);
    cmp_stream("s1");

    // ---- sample 2: all counts 0, zero-wait ACK, early core finish ----
    mem[0] = 8'd0; mem[1] = 8'd0; mem[2] = 8'd0; mem[3] = 8'd0;
    ack_mode = 0;
    build_exp();
    obs_q.delete();
    POS_IN   = 1'b0;
    TRAIN_IN = 1'b1;
    START    = 1'b1;
    k = 0;
    while (k < 200) begin
      step();
      k++;
      START = 1'b0;
      bus.CORE_DONE     = (k == 5);
      bus.CORE_GOODNESS = (k == 5) ? 32'h0000_BEEF : 32'h0;
      if (SAMPLE_DONE) break;
    end
    // 2 timesteps x (4 neurons x 2 cycles + 2 tick cycles), WAIT_DONE, DONE.
    chk("s2_latency", k, 22);
    chk("s2_goodness_early", GOODNESS_OUT, 32'h0000_BEEF);
    chk("s2_is_pos", bus.IS_POS, 0);
    chk("s2_is_train", bus.IS_TRAIN, 1);
    step();
    chk("s2_done_count", n_done, 2);
    cmp_stream("s2");

    // ---- sample 3: ACK withheld on the first event ----
    mem[0] = 8'd3; mem[1] = 8'd0; mem[2] = 8'd0; mem[3] = 8'd0;
    ack_mode = 2;
    obs_q.delete();
    start_sample(1'b1, 1'b0);
    k = 0;
    while (!bus.AERIN_REQ && k < 10) begin
      step();
      k++;
    end
    chk("s3_req_seen", bus.AERIN_REQ, 1);
`ifndef AER_WATCHDOG_EN
    for (int c = 0; c < 50; c++) begin
      chk("s3_req_held", bus.AERIN_REQ, 1);
      chk("s3_addr_stable", bus.AERIN_ADDR, 0);
      if (c == 20) begin
        POS_IN   = 1'b0;
        TRAIN_IN = 1'b1;
        START    = 1'b1;
      end else begin
        START = 1'b0;
      end
      step();
    end
    chk("s3_is_pos_kept", bus.IS_POS, 1);
    chk("s3_is_train_kept", bus.IS_TRAIN, 0);
    chk("s3_one_event", obs_q.size(), 1);
    chk("s3_busy", BUSY, 1);
`else
    k = 0;
    while (!AER_ERR && k < 40) begin
      step();
      k++;
    end
    chk("wd_cycles", k, c_TO);
    chk("wd_aer_err", AER_ERR, 1);
    chk("wd_req_low", bus.AERIN_REQ, 0);
    chk("wd_idle", BUSY, 0);
    chk("wd_no_done", n_done, 2);
    start_sample(1'b1, 1'b0);
    chk("wd_err_cleared", AER_ERR, 0);
    k = 0;
    while (!bus.AERIN_REQ && k < 10) begin
      step();
      k++;
    end
`endif

    // ---- reset mid-handshake ----
    chk("rst_mid_req_before", bus.AERIN_REQ, 1);
    RST = 1'b1;
    step();
    chk("rstm_req", bus.AERIN_REQ, 0);
    chk("rstm_busy", BUSY, 0);
    chk("rstm_addr", bus.AERIN_ADDR, 0);
    chk("rstm_is_pos", bus.IS_POS, 0);
    chk("rstm_rd_en", CNT_RD_EN, 0);
    chk("rstm_goodness", GOODNESS_OUT, 0);
    chk("rstm_aer_err", AER_ERR, 0);
    RST = 1'b0;
    ack_mode = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
